// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and types for the instruction cache.
// Holds the bus width, the default index width and the FSM state encoding.
// No logic; imported by the interface, the array and the top.
package icache_pkg;

  localparam int XLEN      = 32;  // fetch/memory bus width
  localparam int IDX_W_DEF = 8;   // default index width (256 one-word lines)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/icache_if.sv
// icache_if: groups the fetcher-side and memory-controller-side signals of the icache.
// Ports: fetch_valid_i/fetch_pc_i/clear_i in, inst_valid_o/inst_o out (fetcher side);
//        IC_rn/IC_addr out, IC_ready/IC_value in (memory side). slave = cache, master = environment.
interface icache_if;
  import icache_pkg::*;

  logic            fetch_valid_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic            clear_i;
  logic            inst_valid_o;
  logic [XLEN-1:0] inst_o;
  logic            IC_rn;
  logic [XLEN-1:0] IC_addr;
  logic            IC_ready;
  logic [XLEN-1:0] IC_value;

  modport master (
    output fetch_valid_i, fetch_pc_i, clear_i, IC_ready, IC_value,
    input  inst_valid_o, inst_o, IC_rn, IC_addr
  );

  modport slave (
    input  fetch_valid_i, fetch_pc_i, clear_i, IC_ready, IC_value,
    output inst_valid_o, inst_o, IC_rn, IC_addr
  );

endinterface

// File: rtl/icache_array.sv
// icache_array: direct-mapped valid/tag/data storage, one write port, one async read port.
// Latency: read is combinational; a write lands on the clock edge where i_we is high.
// Backpressure: none; the caller gates i_we. rst clears every valid bit (tag/data not reset).
module icache_array #(
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 22,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [DATA_W-1:0] i_wr_dat,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_vld,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [DATA_W-1:0] o_rd_dat
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // A fill always overwrites the indexed line; there is no victim selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_tag[i_wr_idx]   <= i_wr_tag;
      r_data[i_wr_idx]  <= i_wr_dat;
    end
  end

  assign o_rd_vld = r_valid[i_rd_idx];
  assign o_rd_tag = r_tag[i_rd_idx];
  assign o_rd_dat = r_data[i_rd_idx];

endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache with a blocking miss FSM (IDLE/REQ/WAIT).
// Latency: hit -> inst_valid_o 1 cycle after the request; miss -> 1 cycle after IC_ready is sampled in WAIT.
// Backpressure: rdy=0 freezes everything; clear_i cancels the response but an outstanding fill still completes.
// Ports: clk, rst (sync, active-high), rdy, bus (icache_if.slave: fetcher and memory-controller signals).
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  icache_if.slave bus
);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  state_t          r_state;
  logic            r_cancel;
  logic            r_inst_valid;
  logic [XLEN-1:0] r_inst;
  logic            r_ic_rn;
  logic [XLEN-1:0] r_ic_addr;

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_wr_idx;
  logic [TAG_W-1:0] w_wr_tag;
  logic             w_line_vld;
  logic [TAG_W-1:0] w_line_tag;
  logic [XLEN-1:0]  w_line_dat;
  logic             w_hit;
  logic             w_fill;
  logic             w_unused_pc;

  // Lookup uses the live pc; the fill uses the registered miss address, so a
  // fetcher that moves on after clear_i cannot redirect the fill.
  assign w_rd_idx = bus.fetch_pc_i[IDX_W+1:2];
  assign w_rd_tag = bus.fetch_pc_i[XLEN-1:IDX_W+2];
  assign w_wr_idx = r_ic_addr[IDX_W+1:2];
  assign w_wr_tag = r_ic_addr[XLEN-1:IDX_W+2];
  assign w_unused_pc = ^bus.fetch_pc_i[1:0];

  assign w_hit  = w_line_vld && (w_line_tag == w_rd_tag);
  assign w_fill = rdy && (r_state == ST_WAIT) && bus.IC_ready;

  icache_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (XLEN)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_fill),
    .i_wr_idx (w_wr_idx),
    .i_wr_tag (w_wr_tag),
    .i_wr_dat (bus.IC_value),
    .i_rd_idx (w_rd_idx),
    .o_rd_vld (w_line_vld),
    .o_rd_tag (w_line_tag),
    .o_rd_dat (w_line_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cancel     <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_ic_rn      <= 1'b0;
      r_ic_addr    <= '0;
    end else if (!rdy) begin
      r_inst_valid <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.fetch_valid_i && !bus.clear_i) begin
            if (w_hit) begin
              r_inst_valid <= 1'b1;
              r_inst       <= w_line_dat;
            end else begin
              r_ic_addr <= {bus.fetch_pc_i[XLEN-1:2], 2'b00};
              r_ic_rn   <= 1'b1;
              r_cancel  <= 1'b0;
              r_state   <= ST_REQ;
            end
          end
        end
        // One dead cycle: the controller may still show IC_ready from its
        // previous transfer, so it is not looked at here.
        ST_REQ: begin
          if (bus.clear_i) r_cancel <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.IC_ready) begin
            r_ic_rn  <= 1'b0;
            r_cancel <= 1'b0;
            r_state  <= ST_IDLE;
            if (!(r_cancel || bus.clear_i)) begin
              r_inst_valid <= 1'b1;
              r_inst       <= bus.IC_value;
            end
          end else if (bus.clear_i) begin
            r_cancel <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ic_rn <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst_valid_o = r_inst_valid;
  assign bus.inst_o       = r_inst;
  assign bus.IC_rn        = r_ic_rn;
  assign bus.IC_addr      = r_ic_addr;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus randomized fetches checked against a line-level cache model.
// The bench plays both the fetcher and a memory controller with variable latency.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_icache;
  import icache_pkg::*;

  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  icache_if bus();

  icache #(.IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory contents (filled lazily with random words) and cache model.
  logic [31:0]      mem [logic [31:0]];
  logic             m_vld [1 << IW];
  logic [31-IW-2:0] m_tag [1 << IW];
  logic [31:0]      m_dat [1 << IW];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_valid_i = 1'b0;
    bus.clear_i       = 1'b0;
    bus.IC_ready      = 1'b0;
    bus.IC_value      = $urandom;
    rdy               = 1'b1;
  endtask

  task automatic model_flush();
    for (int i = 0; i < (1 << IW); i++) m_vld[i] = 1'b0;
  endtask

  // One fetch request. clr_at: effective cycle after the request edge on which
  // clear_i is raised (0 = REQ cycle, -1 = never). lat: effective cycle on which
  // IC_ready is first driven (>=1). stall_at/stall_n: force rdy=0 cycles there.
  task automatic fetch(input logic [31:0] pc, input bit clr_idle, input int lat,
                       input int clr_at, input int stall_at, input int stall_n,
                       input bit stale, input bit rnd_stall);
    logic [IW-1:0]    idx;
    logic [31-IW-2:0] tag;
    logic [31:0]      addr;
    logic [31:0]      val;
    bit               hit;
    bit               canc;
    bit               done;
    bit               r;
    bit               c;
    bit               rd;
    int               p;
    int               stalls;

    idx  = pc[IW+1:2];
    tag  = pc[31:IW+2];
    addr = {pc[31:2], 2'b00};
    hit  = m_vld[idx] && (m_tag[idx] == tag);

    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = pc;
    bus.clear_i       = clr_idle;
    step();
    bus.fetch_valid_i = 1'b0;
    bus.clear_i       = 1'b0;

    if (clr_idle) begin
      chk("idle_clear_iv", bus.inst_valid_o, 0);
      chk("idle_clear_rn", bus.IC_rn, 0);
      step();
      chk("idle_clear_iv2", bus.inst_valid_o, 0);
      return;
    end

    if (hit) begin
      chk("hit_iv", bus.inst_valid_o, 1);
      chk("hit_inst", bus.inst_o, m_dat[idx]);
      chk("hit_rn", bus.IC_rn, 0);
      step();
      chk("hit_iv_drop", bus.inst_valid_o, 0);
      return;
    end

    chk("miss_rn", bus.IC_rn, 1);
    chk("miss_addr", bus.IC_addr, addr);
    chk("miss_iv", bus.inst_valid_o, 0);

    val    = mem_rd(addr);
    p      = 0;
    canc   = 1'b0;
    done   = 1'b0;
    stalls = 0;
    for (int it = 0; it < 64 && !done; it++) begin
      r = 1'b1;
      if (p == stall_at && stalls < stall_n) begin
        r = 1'b0;
        stalls++;
      end else if (rnd_stall && it < 40 && $urandom_range(0, 4) == 0) begin
        r = 1'b0;
      end
      c  = r && (p == clr_at);
      rd = (p == 0) ? stale : (p >= lat);
      rdy          = r;
      bus.clear_i  = c;
      bus.IC_ready = rd;
      bus.IC_value = rd ? val : $urandom;
      step();
      if (!r) begin
        chk("stall_iv", bus.inst_valid_o, 0);
        chk("stall_rn", bus.IC_rn, 1);
        chk("stall_addr", bus.IC_addr, addr);
      end else if (p == 0 || !rd) begin
        canc = canc | c;
        chk("wait_rn", bus.IC_rn, 1);
        chk("wait_addr", bus.IC_addr, addr);
        chk("wait_iv", bus.inst_valid_o, 0);
        p++;
      end else begin
        canc = canc | c;
        done = 1'b1;
        m_vld[idx] = 1'b1;
        m_tag[idx] = tag;
        m_dat[idx] = val;
        chk("fill_rn", bus.IC_rn, 0);
        chk("fill_iv", bus.inst_valid_o, {31'd0, !canc});
        if (!canc) chk("fill_inst", bus.inst_o, val);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $error("FAIL miss_timeout observed=not_done expected=done");
    end
    idle_inputs();
    step();
    chk("post_iv", bus.inst_valid_o, 0);
    chk("post_rn", bus.IC_rn, 0);
  endtask

  initial begin
    logic [31:0] pc;

    bus.fetch_pc_i = '0;
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_flush();

    // Reset state
    chk("rst_iv", bus.inst_valid_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_rn", bus.IC_rn, 0);
    chk("rst_addr", bus.IC_addr, 0);

    // Cold miss, then hit
    mem[32'h0000_1000] = 32'h0000_0013;
    fetch(32'h0000_1000, 0, 2, -1, -1, 0, 0, 0);
    chk("cold_model", m_dat[8'h00], 32'h0000_0013);
    fetch(32'h0000_1000, 0, 1, -1, -1, 0, 0, 0);

    // Conflict on the same index
    fetch(32'h0000_1400, 0, 2, -1, -1, 0, 0, 0);
    fetch(32'h0000_1000, 0, 3, -1, -1, 0, 0, 0);

    // Flush in WAIT, ready two cycles later; refetch hits
    fetch(32'h0000_2000, 0, 3, 1, -1, 0, 0, 0);
    fetch(32'h0000_2000, 0, 1, -1, -1, 0, 0, 0);

    // rdy low for 3 cycles in WAIT with IC_ready high
    fetch(32'h0000_3000, 0, 1, -1, 1, 3, 0, 0);

    // clear_i in IDLE suppresses a hit; line survives
    fetch(32'h0000_3000, 1, 1, -1, -1, 0, 0, 0);
    fetch(32'h0000_3000, 0, 1, -1, -1, 0, 0, 0);

    // clear_i coincident with IC_ready; flush in REQ; stale ready in REQ
    fetch(32'h0000_4000, 0, 2, 2, -1, 0, 0, 0);
    fetch(32'h0000_4000, 0, 1, -1, -1, 0, 0, 0);
    fetch(32'h0000_4804, 0, 2, 0, -1, 0, 0, 0);
    fetch(32'h0000_5003, 0, 2, -1, -1, 0, 1, 0);

    // Reset mid-miss, then stray IC_ready in IDLE
    bus.fetch_valid_i = 1'b1;
    bus.fetch_pc_i    = 32'h0000_6000;
    step();
    bus.fetch_valid_i = 1'b0;
    chk("rstmid_rn_pre", bus.IC_rn, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_flush();
    chk("rstmid_rn", bus.IC_rn, 0);
    chk("rstmid_addr", bus.IC_addr, 0);
    chk("rstmid_iv", bus.inst_valid_o, 0);
    bus.IC_ready = 1'b1;
    bus.IC_value = 32'hdead_beef;
    step();
    bus.IC_ready = 1'b0;
    chk("stray_iv", bus.inst_valid_o, 0);
    chk("stray_rn", bus.IC_rn, 0);
    fetch(32'h0000_6000, 0, 2, -1, -1, 0, 0, 0);
    fetch(32'h0000_1000, 0, 2, -1, -1, 0, 0, 0);

    // Randomized traffic over a small address window to mix hits and conflicts
    for (int n = 0; n < 250; n++) begin
      pc = ({30'd0, 2'($urandom_range(0, 3))} << (IW + 2))
         | ({28'd0, 4'($urandom_range(0, 15))} << 2)
         | {30'd0, 2'($urandom_range(0, 3))};
      fetch(pc,
            $urandom_range(0, 9) == 0,
            $urandom_range(1, 4),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
            -1, 0,
            $urandom_range(0, 3) == 0,
            1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter IDX_W, default 8, index width (2^IDX_W one-word lines).
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  global enable; low freezes all state and outputs.
REQ-005 SHALL have port fetch_valid_i  input  1  fetcher requests the instruction at fetch_pc_i.
REQ-006 SHALL have port fetch_pc_i  input  32  byte address; bits[1:0] are ignored.
REQ-007 SHALL have port clear_i  input  1  pipeline flush; drops the pending request.
REQ-008 SHALL have port inst_valid_o  output  1  one-cycle pulse; inst_o is valid.
REQ-009 SHALL have port inst_o  output  32  instruction word.
REQ-010 SHALL have port IC_rn  output  1  read request to the memory controller.
REQ-011 SHALL have port IC_addr  output  32  byte address of the word to read.
REQ-012 SHALL have port IC_ready  input  1  memory controller done; IC_value is valid.
REQ-013 SHALL have port IC_value  input  32  little-endian word returned by the memory controller.

Function
REQ-014 SHALL decode index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2].
REQ-015 SHALL keep per-line valid bit, tag and data arrays.
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT.
REQ-017 IDLE, fetch_valid_i=1, hit, clear_i=0: SHALL assert inst_valid_o with the line data on the next cycle (latency 1); stay IDLE.
REQ-018 IDLE, fetch_valid_i=1, miss, clear_i=0: SHALL register IC_addr={pc[31:2],2'b00}, set IC_rn=1, go REQ.
REQ-019 REQ: SHALL hold IC_rn/IC_addr, ignore IC_ready, go WAIT next cycle (absorbs controller ready-deassert delay).
REQ-020 WAIT: SHALL hold IC_rn=1 and IC_addr stable until IC_ready=1 is sampled.
REQ-021 WAIT with IC_ready=1: SHALL write IC_value, tag and valid=1 into the indexed line, drop IC_rn, go IDLE.
REQ-022 In that same edge SHALL drive inst_o=IC_value and pulse inst_valid_o unless the request was cancelled.
REQ-023 clear_i in REQ/WAIT: SHALL set a cancel flag; the memory read still completes and still fills the line, but no inst_valid_o pulse.
REQ-024 clear_i in IDLE: SHALL suppress any response for that cycle's request; clear_i does not invalidate lines.
REQ-025 clear_i coincident with IC_ready: SHALL fill the line and suppress inst_valid_o.
REQ-026 Fetcher SHALL hold fetch_pc_i stable until inst_valid_o or clear_i; icache does not re-sample pc in REQ/WAIT.
REQ-027 SHALL keep inst_valid_o low in every cycle not specified above; at most one pulse per request.
REQ-028 Fill to an already-valid line SHALL overwrite it (direct-mapped, no victim logic).
REQ-029 rdy=0: SHALL hold FSM, arrays and registered outputs unchanged; inst_valid_o held low.

Reset
REQ-030 rst=1 at a clock edge SHALL clear all valid bits, FSM=IDLE, cancel flag=0, IC_rn=0, IC_addr=0, inst_valid_o=0, inst_o=0.
REQ-031 rst SHALL take priority over rdy and every other input.
REQ-032 rst mid-miss SHALL abandon the request; a late IC_ready SHALL be ignored in IDLE.

Structure
REQ-033 FSM state encodings and IDX_W default SHALL live in the shared constants include, beside the bus-width macros.
REQ-034 Tag/valid/data arrays SHALL be one sub-module, icache_array (one write port, one async read port).
REQ-035 No other sub-modules.

Verification
REQ-036 Cold miss: reset, fetch pc=0x0000_1000, mem word 0x0000_0013 -> IC_rn=1, IC_addr=0x1000, REQ then WAIT; inst_valid_o one cycle after IC_ready, inst_o=0x0000_0013.
REQ-037 Hit: refetch 0x1000 -> inst_valid_o next cycle, inst_o=0x0000_0013, IC_rn stays 0.
REQ-038 Conflict: fetch 0x1400 (same index, IDX_W=8) -> miss, fill; then 0x1000 -> miss again.
REQ-039 Flush mid-miss: clear_i in WAIT, IC_ready two cycles later -> no inst_valid_o pulse; refetch of the same pc hits in 1 cycle.
REQ-040 rdy stall: rdy=0 for 3 cycles in WAIT with IC_ready=1 -> no fill; completes on the first rdy=1 cycle.
REQ-041 Reset mid-miss: rst in WAIT -> IC_rn=0 next cycle; a stray IC_ready produces no pulse; refetch misses.
